// File: rtl/alarm_bank.sv
// alarm_bank: multi-channel alarm unit for the digital clock.
// Holds NUM_ALARMS independently editable alarm times, compares each against
// the running BCD time, and runs a per-channel IDLE/RING/SNOOZE machine that
// drives a shared beeping buzzer.
//
// Ports:
//   clk_100MHz, reset_n            system clock, async active-low reset
//   min_1s/min_10s/hr_1s/hr_10s    current time, BCD
//   set_mode                       edit enable, also suppresses triggering
//   sel                            channel being edited and displayed
//   hr_plus1, min_plus1            raw edit buttons
//   snooze, stop                   raw ring-control buttons (broadcast)
//   en                             per-channel arm enable
//   min_1sa/min_10sa/hr_1sa/hr_10sa  BCD alarm time of channel sel
//   ringing                        per-channel RING indicator
//   buzzer                         beeping drive while any channel rings
module alarm_bank #(
    parameter int NUM_ALARMS      = 2,
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SNOOZE_MIN      = 5,
    parameter int RING_TIMEOUT_S  = 60,
    parameter int BEEP_HZ         = 2,
    parameter int SELW            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk_100MHz,
    input  logic                  reset_n,
    input  logic [3:0]            min_1s,
    input  logic [3:0]            min_10s,
    input  logic [3:0]            hr_1s,
    input  logic [3:0]            hr_10s,
    input  logic                  set_mode,
    input  logic [SELW-1:0]       sel,
    input  logic                  hr_plus1,
    input  logic                  min_plus1,
    input  logic                  snooze,
    input  logic                  stop,
    input  logic [NUM_ALARMS-1:0] en,
    output logic [3:0]            min_1sa,
    output logic [3:0]            min_10sa,
    output logic [3:0]            hr_1sa,
    output logic [3:0]            hr_10sa,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic                  buzzer
);

    localparam int DBW          = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam int PW           = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
    localparam int SEC_MAX      = (SNOOZE_TICKS > RING_TIMEOUT_S) ? SNOOZE_TICKS : RING_TIMEOUT_S;
    localparam int SECW         = $clog2(SEC_MAX + 1);
    localparam int HALF_BEEP    = CLK_HZ / (2 * BEEP_HZ);
    localparam int BW           = (HALF_BEEP > 1) ? $clog2(HALF_BEEP) : 1;
    localparam logic [SELW:0] NA_W = (SELW + 1)'(NUM_ALARMS);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    // ---------------- button conditioning ----------------
    logic [3:0]     rawBtn;
    logic [3:0]     sync1_q, sync2_q, stable_q, armed_q, prev_q, pulse_q;
    logic [3:0]     dbWant;
    logic [DBW-1:0] dbCnt_q [4];
    logic           hrPulse, minPulse, snzPulse, stopPulse;

    assign rawBtn = {stop, snooze, min_plus1, hr_plus1};

    // Until a debounced release has been seen the debouncer only hunts for a
    // stable low level, so a button held through reset cannot fire a press.
    assign dbWant = armed_q & ~stable_q;

    assign hrPulse   = pulse_q[0];
    assign minPulse  = pulse_q[1];
    assign snzPulse  = pulse_q[2];
    assign stopPulse = pulse_q[3];

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            armed_q  <= '0;
            prev_q   <= '0;
            pulse_q  <= '0;
            for (int b = 0; b < 4; b++) dbCnt_q[b] <= '0;
        end else begin
            sync1_q <= rawBtn;
            sync2_q <= sync1_q;
            prev_q  <= stable_q;
            pulse_q <= stable_q & ~prev_q;
            for (int b = 0; b < 4; b++) begin
                if (sync2_q[b] == dbWant[b]) begin
                    if (dbCnt_q[b] == DB_LAST) begin
                        dbCnt_q[b] <= '0;
                        if (armed_q[b]) stable_q[b] <= sync2_q[b];
                        else            armed_q[b]  <= 1'b1;
                    end else begin
                        dbCnt_q[b] <= dbCnt_q[b] + 1'b1;
                    end
                end else begin
                    dbCnt_q[b] <= '0;
                end
            end
        end
    end

    // ---------------- alarm storage ----------------
    logic [5:0] almMin_q [NUM_ALARMS];
    logic [4:0] almHr_q  [NUM_ALARMS];
    logic       selValid;

    assign selValid = ({1'b0, sel} < NA_W);

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                almMin_q[i] <= '0;
                almHr_q[i]  <= '0;
            end
        end else if (set_mode && selValid) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (sel == SELW'(i)) begin
                    if (minPulse) almMin_q[i] <= (almMin_q[i] == 6'd59) ? 6'd0 : almMin_q[i] + 6'd1;
                    if (hrPulse)  almHr_q[i]  <= (almHr_q[i] == 5'd23) ? 5'd0 : almHr_q[i] + 5'd1;
                end
            end
        end
    end

    // ---------------- display ----------------
    logic [5:0] selMin;
    logic [4:0] selHr;

    always_comb begin
        selMin = '0;
        selHr  = '0;
        if (selValid) begin
            selMin = almMin_q[sel];
            selHr  = almHr_q[sel];
        end
    end

    assign min_10sa = 4'(selMin / 6'd10);
    assign min_1sa  = 4'(selMin % 6'd10);
    assign hr_10sa  = 4'(selHr / 5'd10);
    assign hr_1sa   = 4'(selHr % 5'd10);

    // ---------------- match detection ----------------
    logic [6:0]            curMin, curHr;
    logic [NUM_ALARMS-1:0] match, match_q, trigger;

    assign curMin = 7'(min_10s) * 7'd10 + 7'(min_1s);
    assign curHr  = 7'(hr_10s) * 7'd10 + 7'(hr_1s);

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_ALARMS; i++)
            match[i] = ({1'b0, almMin_q[i]} == curMin) && ({2'b0, almHr_q[i]} == curHr);
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) match_q <= '0;
        else          match_q <= match;
    end

    // ---------------- 1 s timebase ----------------
    logic [PW-1:0] pre_q;
    logic          tick;

    assign tick = (pre_q == PW'(CLK_HZ - 1));

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n)  pre_q <= '0;
        else if (tick) pre_q <= '0;
        else           pre_q <= pre_q + 1'b1;
    end

    // ---------------- per-channel FSM ----------------
    state_t          state_q [NUM_ALARMS];
    state_t          state_d [NUM_ALARMS];
    logic [SECW-1:0] sec_q   [NUM_ALARMS];
    logic [SECW-1:0] sec_d   [NUM_ALARMS];

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i] <= IDLE;
                sec_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i] <= state_d[i];
                sec_q[i]   <= sec_d[i];
            end
        end
    end

    assign trigger = match & ~match_q & en & {NUM_ALARMS{~set_mode}};

    // Priority: disarm, then stop, then snooze, then tick-based timeout.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            state_d[i] = state_q[i];
            sec_d[i]   = sec_q[i];
            if (!en[i]) begin
                state_d[i] = IDLE;
                sec_d[i]   = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (trigger[i]) begin
                            state_d[i] = RING;
                            sec_d[i]   = '0;
                        end
                    end
                    RING: begin
                        if (stopPulse) begin
                            state_d[i] = IDLE;
                        end else if (snzPulse) begin
                            state_d[i] = SNOOZE;
                            sec_d[i]   = '0;
                        end else if (tick) begin
                            if (sec_q[i] == SECW'(RING_TIMEOUT_S - 1)) state_d[i] = IDLE;
                            else                                         sec_d[i]   = sec_q[i] + 1'b1;
                        end
                    end
                    SNOOZE: begin
                        if (stopPulse) begin
                            state_d[i] = IDLE;
                        end else if (tick) begin
                            if (sec_q[i] == SECW'(SNOOZE_TICKS - 1)) begin
                                state_d[i] = RING;
                                sec_d[i]   = '0;
                            end else begin
                                sec_d[i] = sec_q[i] + 1'b1;
                            end
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        ringing = '0;
        for (int i = 0; i < NUM_ALARMS; i++) ringing[i] = (state_q[i] == RING);
    end

    // ---------------- buzzer ----------------
    // The phase idles high so the first beep starts as soon as a ring begins.
    logic [BW-1:0] beepDiv_q;
    logic          phase_q, buzzer_q, anyRing;

    assign anyRing = |ringing;
    assign buzzer  = buzzer_q;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            beepDiv_q <= '0;
            phase_q   <= 1'b1;
            buzzer_q  <= 1'b0;
        end else begin
            buzzer_q <= anyRing & phase_q;
            if (!anyRing) begin
                beepDiv_q <= '0;
                phase_q   <= 1'b1;
            end else if (beepDiv_q == BW'(HALF_BEEP - 1)) begin
                beepDiv_q <= '0;
                phase_q   <= ~phase_q;
            end else begin
                beepDiv_q <= beepDiv_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: scenario bench for alarm_bank with a small model of the
// alarm times and tick arithmetic for ring/snooze timing.
module tb_alarm_bank;

    localparam int NA     = 2;
    localparam int CLKHZ  = 1000;
    localparam int DB     = 4;
    localparam int SNZMIN = 1;
    localparam int RTO    = 3;
    localparam int BEEP   = 125;
    localparam int HALF   = CLKHZ / (2 * BEEP);

    logic        clk_100MHz = 1'b0;
    logic        reset_n;
    logic [3:0]  min_1s, min_10s, hr_1s, hr_10s;
    logic        set_mode;
    logic [0:0]  sel;
    logic        hr_plus1, min_plus1, snooze, stop;
    logic [1:0]  en;
    logic [3:0]  min_1sa, min_10sa, hr_1sa, hr_10sa;
    logic [1:0]  ringing;
    logic        buzzer;
    logic [15:0] shown;

    int checks = 0;
    int errors = 0;
    int cyc;
    int mMin [NA];
    int mHr  [NA];

    always #5 clk_100MHz = ~clk_100MHz;

    // Edges seen since reset release; ticks land on multiples of CLKHZ.
    always @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    assign shown = {hr_10sa, hr_1sa, min_10sa, min_1sa};

    alarm_bank #(
        .NUM_ALARMS(NA), .CLK_HZ(CLKHZ), .DEBOUNCE_CYCLES(DB),
        .SNOOZE_MIN(SNZMIN), .RING_TIMEOUT_S(RTO), .BEEP_HZ(BEEP)
    ) dut (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n),
        .min_1s(min_1s), .min_10s(min_10s), .hr_1s(hr_1s), .hr_10s(hr_10s),
        .set_mode(set_mode), .sel(sel),
        .hr_plus1(hr_plus1), .min_plus1(min_plus1), .snooze(snooze), .stop(stop),
        .en(en),
        .min_1sa(min_1sa), .min_10sa(min_10sa), .hr_1sa(hr_1sa), .hr_10sa(hr_10sa),
        .ringing(ringing), .buzzer(buzzer)
    );

    function automatic logic [15:0] bcd(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    task automatic setTime(input int h, input int m);
        hr_10s  = 4'(h / 10);
        hr_1s   = 4'(h % 10);
        min_10s = 4'(m / 10);
        min_1s  = 4'(m % 10);
    endtask

    // which: 0 hr, 1 min, 2 snooze, 3 stop, 4 hr+min together
    task automatic setRaw(input int which, input logic v);
        case (which)
            0: hr_plus1 = v;
            1: min_plus1 = v;
            2: snooze = v;
            3: stop = v;
            default: begin hr_plus1 = v; min_plus1 = v; end
        endcase
    endtask

    task automatic pressBtn(input int which);
        int hold;
        hold = $urandom_range(5, 8);
        setRaw(which, 1'b1);
        step(hold);
        setRaw(which, 1'b0);
        step(8);
        if (set_mode) begin
            if (which == 0 || which == 4) mHr[sel]  = (mHr[sel] + 1) % 24;
            if (which == 1 || which == 4) mMin[sel] = (mMin[sel] + 1) % 60;
        end
    endtask

    task automatic setAlarm(input int ch, input int h, input int m);
        int nm, nh, nb;
        sel = 1'(ch);
        set_mode = 1'b1;
        step(1);
        nm = (m - mMin[ch] + 60) % 60;
        nh = (h - mHr[ch] + 24) % 24;
        nb = (nm < nh) ? nm : nh;
        for (int k = 0; k < nb; k++) pressBtn(4);
        for (int k = nb; k < nm; k++) pressBtn(1);
        for (int k = nb; k < nh; k++) pressBtn(0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        setTime(9, 59);
        set_mode = 1'b0; sel = '0; en = '0;
        hr_plus1 = 1'b0; min_plus1 = 1'b0; snooze = 1'b0; stop = 1'b0;
        for (int i = 0; i < NA; i++) begin mMin[i] = 0; mHr[i] = 0; end
        step(3);
        checks++;
        if (ringing !== 2'b00 || buzzer !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: ringing=%b buzzer=%b expected 00/0", ringing, buzzer);
        end
        checks++;
        if (shown !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_display: got %h expected 0000", shown);
        end
        reset_n = 1'b1;
        step(10);
    endtask

    task automatic test_press_handling();
        int extra;
        set_mode = 1'b1;
        sel = 1'b1;
        step(1);
        min_plus1 = 1'b1;
        step(DB + 3);
        checks++;
        if (shown !== bcd(0, 0)) begin
            errors++;
            $display("[TB] FAIL press_latency_early: got %h expected %h", shown, bcd(0, 0));
        end
        step(1);
        mMin[1] = 1;
        checks++;
        if (shown !== bcd(0, 1)) begin
            errors++;
            $display("[TB] FAIL press_latency: got %h expected %h", shown, bcd(0, 1));
        end
        step(50 - DB - 4);
        min_plus1 = 1'b0;
        step(8);
        checks++;
        if (shown !== bcd(0, 1)) begin
            errors++;
            $display("[TB] FAIL press_hold_once: got %h expected %h", shown, bcd(0, 1));
        end
        min_plus1 = 1'b1;
        step(2);
        min_plus1 = 1'b0;
        step(10);
        checks++;
        if (shown !== bcd(0, 1)) begin
            errors++;
            $display("[TB] FAIL press_glitch: got %h expected %h", shown, bcd(0, 1));
        end
        extra = $urandom_range(0, 3);
        for (int k = 0; k < 59 + extra; k++) pressBtn(1);
        checks++;
        if (shown !== bcd(0, extra) || mMin[1] != extra) begin
            errors++;
            $display("[TB] FAIL press_min_wrap: got %h expected %h", shown, bcd(0, extra));
        end
        set_mode = 1'b0;
        pressBtn(1);
        checks++;
        if (shown !== bcd(mHr[1], mMin[1])) begin
            errors++;
            $display("[TB] FAIL press_no_setmode: got %h expected %h", shown, bcd(mHr[1], mMin[1]));
        end
        sel = 1'b0;
        step(1);
        checks++;
        if (shown !== bcd(0, 0)) begin
            errors++;
            $display("[TB] FAIL press_other_channel: got %h expected %h", shown, bcd(0, 0));
        end
    endtask

    task automatic test_edit_random();
        int h, m;
        for (int ch = 0; ch < NA; ch++) begin
            h = $urandom_range(0, 23);
            m = $urandom_range(0, 59);
            setAlarm(ch, h, m);
            checks++;
            if (shown !== bcd(h, m)) begin
                errors++;
                $display("[TB] FAIL edit_random ch%0d: got %h expected %h", ch, shown, bcd(h, m));
            end
        end
        sel = 1'b0;
        step(1);
        checks++;
        if (shown !== bcd(mHr[0], mMin[0])) begin
            errors++;
            $display("[TB] FAIL edit_keep_ch0: got %h expected %h", shown, bcd(mHr[0], mMin[0]));
        end
    endtask

    task automatic test_ring_timeout();
        int e, x, guard;
        logic expBuz;
        setTime(6, 0);
        setAlarm(0, 7, 30);
        set_mode = 1'b0;
        en = 2'b01;
        step(2);
        setTime(7, 30);
        step(1);
        e = cyc;
        checks++;
        if (ringing !== 2'b01) begin
            errors++;
            $display("[TB] FAIL ring_entry: ringing=%b expected 01", ringing);
        end
        for (int k = 1; k <= 4 * HALF; k++) begin
            step(1);
            expBuz = (((k - 1) / HALF) % 2) == 0;
            checks++;
            if (buzzer !== expBuz) begin
                errors++;
                $display("[TB] FAIL buzzer_beep k=%0d: got %b expected %b", k, buzzer, expBuz);
            end
        end
        x = (e / CLKHZ + RTO) * CLKHZ;
        guard = 0;
        while (cyc < x - 1 && guard < 5000) begin step(1); guard++; end
        checks++;
        if (cyc != x - 1 || ringing !== 2'b01) begin
            errors++;
            $display("[TB] FAIL ring_before_timeout: cyc=%0d ringing=%b expected %0d/01", cyc, ringing, x - 1);
        end
        step(1);
        checks++;
        if (ringing !== 2'b00) begin
            errors++;
            $display("[TB] FAIL ring_timeout: ringing=%b expected 00", ringing);
        end
        step(1);
        checks++;
        if (buzzer !== 1'b0) begin
            errors++;
            $display("[TB] FAIL buzzer_after_timeout: got %b expected 0", buzzer);
        end
    endtask

    task automatic test_snooze();
        int s, r, guard;
        setTime(7, 31);
        step(2);
        setTime(7, 30);
        step(1);
        checks++;
        if (ringing !== 2'b01) begin
            errors++;
            $display("[TB] FAIL snooze_retrigger: ringing=%b expected 01", ringing);
        end
        snooze = 1'b1;
        step(DB + 3);
        checks++;
        if (ringing !== 2'b01) begin
            errors++;
            $display("[TB] FAIL snooze_early: ringing=%b expected 01", ringing);
        end
        step(1);
        s = cyc;
        checks++;
        if (ringing !== 2'b00) begin
            errors++;
            $display("[TB] FAIL snooze_enter: ringing=%b expected 00", ringing);
        end
        step(1);
        checks++;
        if (buzzer !== 1'b0) begin
            errors++;
            $display("[TB] FAIL snooze_buzzer: got %b expected 0", buzzer);
        end
        snooze = 1'b0;
        r = (s / CLKHZ + SNZMIN * 60) * CLKHZ;
        guard = 0;
        while (cyc < r - 1 && guard < 70000) begin step(1); guard++; end
        checks++;
        if (cyc != r - 1 || ringing !== 2'b00) begin
            errors++;
            $display("[TB] FAIL snooze_hold: cyc=%0d ringing=%b expected %0d/00", cyc, ringing, r - 1);
        end
        step(1);
        checks++;
        if (ringing !== 2'b01) begin
            errors++;
            $display("[TB] FAIL snooze_rering: ringing=%b expected 01", ringing);
        end
        stop = 1'b1;
        step(DB + 4);
        checks++;
        if (ringing !== 2'b00) begin
            errors++;
            $display("[TB] FAIL stop_exit: ringing=%b expected 00", ringing);
        end
        stop = 1'b0;
        step(40);
        checks++;
        if (ringing !== 2'b00) begin
            errors++;
            $display("[TB] FAIL stop_no_retrigger: ringing=%b expected 00", ringing);
        end
    endtask

    task automatic test_simultaneous();
        en = 2'b00;
        setTime(9, 59);
        setAlarm(0, 12, 0);
        setAlarm(1, 12, 0);
        checks++;
        if (shown !== bcd(12, 0)) begin
            errors++;
            $display("[TB] FAIL simul_setup: got %h expected %h", shown, bcd(12, 0));
        end
        set_mode = 1'b0;
        en = 2'b11;
        step(2);
        setTime(12, 0);
        step(1);
        checks++;
        if (ringing !== 2'b11) begin
            errors++;
            $display("[TB] FAIL simul_ring: ringing=%b expected 11", ringing);
        end
        stop = 1'b1;
        step(DB + 4);
        checks++;
        if (ringing !== 2'b00) begin
            errors++;
            $display("[TB] FAIL simul_stop: ringing=%b expected 00", ringing);
        end
        stop = 1'b0;
        step(8);
        setTime(12, 1);
        step(2);
        setTime(12, 0);
        step(1);
        checks++;
        if (ringing !== 2'b11) begin
            errors++;
            $display("[TB] FAIL simul_ring2: ringing=%b expected 11", ringing);
        end
        en = 2'b01;
        step(1);
        checks++;
        if (ringing !== 2'b01) begin
            errors++;
            $display("[TB] FAIL simul_disarm: ringing=%b expected 01", ringing);
        end
        en = 2'b00;
        step(1);
        checks++;
        if (ringing !== 2'b00) begin
            errors++;
            $display("[TB] FAIL simul_disarm_all: ringing=%b expected 00", ringing);
        end
    endtask

    task automatic test_edit_no_trigger();
        set_mode = 1'b1;
        sel = 1'b0;
        setTime(mHr[0], (mMin[0] + 1) % 60);
        en = 2'b01;
        step(2);
        pressBtn(1);
        checks++;
        if (ringing !== 2'b00 || shown !== bcd(12, 1)) begin
            errors++;
            $display("[TB] FAIL edit_no_trigger: ringing=%b shown=%h expected 00/%h", ringing, shown, bcd(12, 1));
        end
        set_mode = 1'b0;
        step(6);
        checks++;
        if (ringing !== 2'b00) begin
            errors++;
            $display("[TB] FAIL edit_release_no_trigger: ringing=%b expected 00", ringing);
        end
    endtask

    task automatic test_reset_mid_ring();
        setTime(12, 2);
        step(2);
        setTime(12, 1);
        step(1);
        checks++;
        if (ringing !== 2'b01) begin
            errors++;
            $display("[TB] FAIL midring_setup: ringing=%b expected 01", ringing);
        end
        set_mode = 1'b1;
        sel = 1'b0;
        hr_plus1 = 1'b1;
        step(3);
        reset_n = 1'b0;
        #2;
        checks++;
        if (ringing !== 2'b00 || buzzer !== 1'b0 || shown !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL midring_reset: ringing=%b buzzer=%b shown=%h expected 00/0/0000", ringing, buzzer, shown);
        end
        @(posedge clk_100MHz);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < NA; i++) begin mMin[i] = 0; mHr[i] = 0; end
        step(30);
        checks++;
        if (shown !== bcd(0, 0) || ringing !== 2'b00) begin
            errors++;
            $display("[TB] FAIL held_after_reset: shown=%h ringing=%b expected %h/00", shown, ringing, bcd(0, 0));
        end
        hr_plus1 = 1'b0;
        step(10);
        pressBtn(0);
        checks++;
        if (shown !== bcd(1, 0) || mHr[0] != 1) begin
            errors++;
            $display("[TB] FAIL repress_after_reset: got %h expected %h", shown, bcd(1, 0));
        end
    endtask

    initial begin
        test_reset();
        test_press_handling();
        test_edit_random();
        test_ring_timeout();
        test_snooze();
        test_simultaneous();
        test_edit_no_trigger();
        test_reset_mid_ring();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_bank.md
# alarm_bank

Multi-channel alarm unit for the digital clock. It replaces the single alarm register with `NUM_ALARMS` independently settable and enabled alarm times. Button inputs are debounced and edge-detected, so one press gives exactly one increment. Each channel compares its time against the running clock's BCD time and runs a ring/snooze/timeout state machine driving a shared beeping buzzer output. It sits beside the timekeeping counter and feeds the `seg_controlll`-style display mux through BCD outputs for the selected channel.

## Interface
Parameters:
- `NUM_ALARMS`, 2: number of channels, 1..4.
- `CLK_HZ`, 100_000_000: clock frequency; sets the 1 s prescaler.
- `DEBOUNCE_CYCLES`, 1_000_000: cycles a synchronised button level must stay stable before it is accepted.
- `SNOOZE_MIN`, 5: snooze length in minutes (counted as `SNOOZE_MIN`*60 one-second ticks).
- `RING_TIMEOUT_S`, 60: ring auto-stop in seconds.
- `BEEP_HZ`, 2: buzzer on/off rate. `CLK_HZ` must be divisible by 2*`BEEP_HZ`.
- `SELW`, derived: max(1, clog2(`NUM_ALARMS`)).

Ports:
- `clk_100MHz`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `min_1s`, `min_10s`, `hr_1s`, `hr_10s`  in  4 each  current time, BCD.
- `set_mode`  in  1  level; enables editing and suppresses triggering.
- `sel`  in  `SELW`  channel being edited and displayed.
- `hr_plus1`, `min_plus1`  in  1  raw edit buttons.
- `snooze`, `stop`  in  1  raw ring-control buttons.
- `en`  in  `NUM_ALARMS`  per-channel arm enable, level.
- `min_1sa`, `min_10sa`, `hr_1sa`, `hr_10sa`  out  4 each  BCD alarm time of channel `sel`.
- `ringing`  out  `NUM_ALARMS`  1 while that channel is in RING.
- `buzzer`  out  1  beeping drive while any channel rings.

## Operation
- **Button conditioning.** Each of the four buttons passes through a 2-flop synchroniser, then a stability counter, then a rising-edge detector. The result is a 1-cycle pulse per accepted press. Holding a button produces no repeat pulses.
- **Alarm storage.** Per channel: minutes are 6-bit binary (0..59) and hours are 5-bit binary (0..23).
  - Reset value is 00:00.
  - A `min_plus1` pulse with `set_mode`=1 increments channel `sel`'s minutes. 59 wraps to 0 with no carry into hours.
  - A `hr_plus1` pulse increments hours. 23 wraps to 0.
  - Both pulses in the same cycle: both fields increment.
  - Pulses with `set_mode`=0, or with `sel` ≥ `NUM_ALARMS`, are discarded.
- **Display outputs.** BCD conversion of channel `sel`, combinational from the stored registers. When `sel` ≥ `NUM_ALARMS`, all four outputs are 0.
- **Match detection.** `match[i]` is 1 when the stored time equals the input BCD time. `match_q[i]` is a registered copy, updated every cycle including during `set_mode`.
- **Trigger condition.** A channel triggers when `match` & ~`match_q` & `en[i]` & ~`set_mode` & state==IDLE.
- **Timebase.** A 1 s tick is a 1-cycle pulse every `CLK_HZ` cycles from a free-running prescaler. The first tick comes `CLK_HZ` cycles after reset release.
- **Per-channel FSM** (states IDLE, RING, SNOOZE):
  - IDLE → RING on trigger. The second counter clears.
  - RING → IDLE on a `stop` pulse, or on the `RING_TIMEOUT_S`-th tick after entry.
  - RING → SNOOZE on a `snooze` pulse. The second counter clears.
  - SNOOZE → RING on the (`SNOOZE_MIN`*60)-th tick after entry. The second counter clears.
  - SNOOZE → IDLE on a `stop` pulse.
  - Any state → IDLE when `en[i]`=0.
- **FSM priority.** `en[i]`=0, then `stop`, then `snooze`, then timeout.
- **Broadcast controls.** `snooze` and `stop` act on every channel at once. `snooze` affects RING channels only.
- **Buzzer.** A beep phase flop toggles every `CLK_HZ`/(2*`BEEP_HZ`) cycles while any channel is in RING. It is held at 1 with its divider cleared while no channel rings. `buzzer` = registered (any RING & phase).

## Timing
- **Reset.** Asserting `reset_n`=0 at any time, including mid-ring or mid-press, immediately forces:
  - all alarm times to 00:00, all FSMs to IDLE, `match_q`=0;
  - all debouncers to released, all counters and prescalers to 0;
  - outputs `ringing`=0, `buzzer`=0, BCD outputs 0.
- **Button latency.** A clean raw rising edge yields its pulse exactly `DEBOUNCE_CYCLES`+3 cycles later. A glitch shorter than `DEBOUNCE_CYCLES` cycles yields no pulse.
- **Edit latency.** A stored time and the BCD outputs change 1 cycle after the pulse.
- **Ring entry.** `ringing[i]` rises 1 cycle after the input time reaches the match. `buzzer` rises 1 cycle after `ringing`.
- **Ring exit.** On a `stop` or `snooze` pulse, `ringing` falls 1 cycle later and `buzzer` falls 2 cycles later.
- **Tick-counted intervals.** Timeout and snooze are counted in whole ticks, so real duration is short by up to 1 s.

## Test plan
Bench parameters: `CLK_HZ`=1000, `DEBOUNCE_CYCLES`=4, `NUM_ALARMS`=2, `SNOOZE_MIN`=1, `RING_TIMEOUT_S`=3, `BEEP_HZ`=125.

1. **Press handling.** `set_mode`=1, `sel`=1; hold `min_plus1` for 50 cycles → channel 1 reads 00:01 exactly once. A 2-cycle glitch → no change. 60 presses → reads 00:00, hours unchanged.
2. **Ring and timeout.** Channel 0 set to 07:30, `en`=01, `set_mode`=0; drive the time to 07:30 → `ringing`=01 next cycle. `buzzer` toggles every 4 cycles. `ringing` clears on the 3rd tick.
3. **Snooze cycle.** Channel 0 ringing; press `snooze` → SNOOZE and `buzzer`=0. After 60 ticks → RING again. Press `stop` → IDLE, with no retrigger while the time stays 07:30.
4. **Simultaneous channels.** Both channels set to 12:00, `en`=11 → `ringing`=11. One `stop` → 00. Clear `en[1]` mid-ring → `ringing[1]` falls next cycle.
5. **No trigger while editing.** With `set_mode`=1, stepping channel 0 onto the current time → no ring. Deassert `set_mode` → still no ring.
6. **Reset mid-ring.** Pulse `reset_n` low for 1 cycle while ringing in the middle of a button press → all outputs 0 and times 00:00. The held button gives no pulse until it is released and pressed again.
